// File: rtl/keypad_row_decoder_if.sv
// Pin-side bundle of the keypad row decoder: column sense in; row strobe and key events out.
interface keypad_row_decoder_if;
   logic [2:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       key_err;

   modport slave  (input col_in, output row_out, key_code, key_valid, key_held, key_err);
   modport master (output col_in, input row_out, key_code, key_valid, key_held, key_err);
endinterface

// File: rtl/keypad_row_decoder.sv
// 4x3 keypad scanner: strobes rows, debounces the synchronized columns, emits key events.
// state      | meaning
// S_SCAN     | rotating row strobe, looking for a nonzero column
// S_DEBOUNCE | row frozen, counting samples identical to the latched columns
// S_PRESSED  | key accepted (or rejected as multi-column), waiting for zero columns
// S_RELEASE  | counting consecutive zero samples before resuming the scan
module keypad_row_decoder #(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 8
) (
   input  logic               clk,
   input  logic               rst,
   keypad_row_decoder_if.slave kp
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIV_SETTLE = DW'(3);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   state_t         state, state_n;
   logic [2:0]     col_m, col_s;
   logic [2:0]     col_lat, col_lat_n;
   logic [DW-1:0]  div, div_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [3:0]     row, row_n;
   logic [3:0]     code, code_n;
   logic           valid, valid_n;
   logic           held, held_n;
   logic           err, err_n;
   logic           one_hot;

   function automatic logic [3:0] decode(input logic [3:0] r, input logic [2:0] c);
      case ({r, c})
         7'b0001_001: decode = 4'd1;
         7'b0001_010: decode = 4'd2;
         7'b0001_100: decode = 4'd3;
         7'b0010_001: decode = 4'd4;
         7'b0010_010: decode = 4'd5;
         7'b0010_100: decode = 4'd6;
         7'b0100_001: decode = 4'd7;
         7'b0100_010: decode = 4'd8;
         7'b0100_100: decode = 4'd9;
         7'b1000_001: decode = 4'd10;
         7'b1000_100: decode = 4'd11;
         default:     decode = 4'd0;
      endcase
   endfunction

   assign one_hot = (col_lat & (col_lat - 3'd1)) == 3'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_m   <= '0;
         col_s   <= '0;
         state   <= S_SCAN;
         col_lat <= '0;
         div     <= '0;
         cnt     <= '0;
         row     <= 4'b0001;
         code    <= '0;
         valid   <= 1'b0;
         held    <= 1'b0;
         err     <= 1'b0;
      end else begin
         col_m   <= kp.col_in;
         col_s   <= col_m;
         state   <= state_n;
         col_lat <= col_lat_n;
         div     <= div_n;
         cnt     <= cnt_n;
         row     <= row_n;
         code    <= code_n;
         valid   <= valid_n;
         held    <= held_n;
         err     <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      col_lat_n = col_lat;
      div_n     = div;
      cnt_n     = cnt;
      row_n     = row;
      code_n    = code;
      valid_n   = 1'b0;
      held_n    = held;
      err_n     = 1'b0;
      case (state)
         S_SCAN: begin
            // a press seen on the last divider count wins over the row rotation
            if (div >= DIV_SETTLE && col_s != 3'b000) begin
               col_lat_n = col_s;
               cnt_n     = '0;
               state_n   = S_DEBOUNCE;
            end else if (div == DIV_LAST) begin
               div_n = '0;
               row_n = {row[2:0], row[3]};
            end else begin
               div_n = div + DW'(1);
            end
         end
         S_DEBOUNCE: begin
            if (col_s != col_lat) begin
               div_n   = DIV_SETTLE;
               state_n = S_SCAN;
            end else if (cnt == CNT_LAST) begin
               state_n = S_PRESSED;
               if (one_hot) begin
                  code_n  = decode(row, col_lat);
                  valid_n = 1'b1;
                  held_n  = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_PRESSED: begin
            if (col_s == 3'b000) begin
               cnt_n   = '0;
               state_n = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (col_s != 3'b000) begin
               state_n = S_PRESSED;
            end else if (cnt == CNT_LAST) begin
               held_n  = 1'b0;
               row_n   = {row[2:0], row[3]};
               div_n   = '0;
               state_n = S_SCAN;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = S_SCAN;
      endcase
   end

   assign kp.row_out   = row;
   assign kp.key_code  = code;
   assign kp.key_valid = valid;
   assign kp.key_held  = held;
   assign kp.key_err   = err;
endmodule

// File: tb/tb_keypad_row_decoder.sv
// Bench for keypad_row_decoder: directed keypad scenarios plus random presses against a behavioural model.
module tb_keypad_row_decoder;
   localparam int SCAN_DIV = 8;
   localparam int DEBOUNCE = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_valid = 0;
   int   n_err = 0;

   keypad_row_decoder_if kif();

   keypad_row_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk),
      .rst(rst),
      .kp (kif.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model: keys as a row/column lookup table, timing kept as plain integer counters.
   int         kmap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
   logic [2:0] m_s1 = '0, m_s2 = '0, m_lat = '0;
   int         m_phase = 0, m_row = 0, m_tick = 0, m_run = 0;
   logic [3:0] m_code = '0;
   logic       m_valid = 1'b0, m_held = 1'b0, m_err = 1'b0;

   function automatic int col_idx(input logic [2:0] c);
      return (c == 3'b001) ? 0 : (c == 3'b010) ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lat = '0;
      m_phase = 0; m_row = 0; m_tick = 0; m_run = 0;
      m_code = '0; m_valid = 1'b0; m_held = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      logic [2:0] s;
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = kif.col_in;
      m_valid = 1'b0;
      m_err = 1'b0;
      case (m_phase)
         0: begin
            if (m_tick >= 3 && s != 3'b000) begin
               m_lat = s; m_run = 0; m_phase = 1;
            end else if (m_tick == SCAN_DIV - 1) begin
               m_tick = 0; m_row = (m_row + 1) % 4;
            end else begin
               m_tick++;
            end
         end
         1: begin
            if (s != m_lat) begin
               m_phase = 0; m_tick = 3;
            end else begin
               m_run++;
               if (m_run == DEBOUNCE) begin
                  m_phase = 2;
                  if ($countones(m_lat) == 1) begin
                     m_code = 4'(kmap[m_row][col_idx(m_lat)]);
                     m_valid = 1'b1;
                     m_held = 1'b1;
                  end else begin
                     m_err = 1'b1;
                  end
               end
            end
         end
         2: if (s == 3'b000) begin m_run = 0; m_phase = 3; end
         default: begin
            if (s != 3'b000) begin
               m_phase = 2;
            end else begin
               m_run++;
               if (m_run == DEBOUNCE) begin
                  m_held = 1'b0; m_row = (m_row + 1) % 4; m_tick = 0; m_phase = 0;
               end
            end
         end
      endcase
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("row_out",   int'(kif.row_out),   1 << m_row);
      chk("key_code",  int'(kif.key_code),  int'(m_code));
      chk("key_valid", int'(kif.key_valid), int'(m_valid));
      chk("key_held",  int'(kif.key_held),  int'(m_held));
      chk("key_err",   int'(kif.key_err),   int'(m_err));
      chk("valid_err_exclusive", int'(kif.key_valid & kif.key_err), 0);
      if (kif.key_valid) n_valid++;
      if (kif.key_err)   n_err++;
   end

   task automatic drive(input logic [2:0] v, input int n);
      kif.col_in = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // returns just after the strobe moves onto the target row
   task automatic wait_row_entry(input logic [3:0] target);
      int i;
      i = 0;
      while (kif.row_out == target && i < 300) begin @(posedge clk); #2; i++; end
      while (kif.row_out != target && i < 300) begin @(posedge clk); #2; i++; end
      if (i >= 300) begin
         checks++;
         errors++;
         $display("FAIL row_wait_timeout: got row %b required %b", kif.row_out, target);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_row"},   int'(kif.row_out),   1);
      chk({tag, "_code"},  int'(kif.key_code),  0);
      chk({tag, "_valid"}, int'(kif.key_valid), 0);
      chk({tag, "_held"},  int'(kif.key_held),  0);
      chk({tag, "_err"},   int'(kif.key_err),   0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1);
   end

   initial begin
      int v0, e0;
      int exp_rows [4] = '{2, 4, 8, 1};
      kif.col_in = 3'b000;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_values("reset");
      rst = 1'b1;

      // idle rotation: one row step every SCAN_DIV clocks
      for (int k = 0; k < 4; k++) begin
         repeat (SCAN_DIV) @(posedge clk);
         #2;
         chk("idle_row", int'(kif.row_out), exp_rows[k]);
      end

      // key '5'
      v0 = n_valid;
      wait_row_entry(4'b0010);
      drive(3'b010, 20);
      drive(3'b000, 12);
      chk("key5_pulses", n_valid - v0, 1);
      chk("key5_code", int'(kif.key_code), 5);
      chk("key5_next_row", int'(kif.row_out), 4'b0100);
      chk("key5_held_after", int'(kif.key_held), 0);

      // '#' with bounce
      v0 = n_valid;
      wait_row_entry(4'b1000);
      drive(3'b100, 1); drive(3'b000, 1); drive(3'b100, 1); drive(3'b000, 1);
      drive(3'b100, 15);
      drive(3'b000, 12);
      chk("hash_pulses", n_valid - v0, 1);
      chk("hash_code", int'(kif.key_code), 11);

      // two columns on row0
      v0 = n_valid; e0 = n_err;
      wait_row_entry(4'b0001);
      drive(3'b011, 15);
      drive(3'b000, 12);
      chk("multi_err_pulses", n_err - e0, 1);
      chk("multi_valid_pulses", n_valid - v0, 0);
      chk("multi_code_kept", int'(kif.key_code), 11);
      chk("multi_held", int'(kif.key_held), 0);

      // '0', column change while pressed, one-cycle release glitch
      v0 = n_valid; e0 = n_err;
      wait_row_entry(4'b1000);
      drive(3'b010, 10);
      drive(3'b001, 6);
      drive(3'b000, 1);
      drive(3'b001, 4);
      chk("zero_held_through_glitch", int'(kif.key_held), 1);
      drive(3'b000, 12);
      chk("zero_pulses", n_valid - v0, 1);
      chk("zero_err_pulses", n_err - e0, 0);
      chk("zero_code", int'(kif.key_code), 0);

      // reset during debounce
      wait_row_entry(4'b0010);
      drive(3'b001, 5);
      rst = 1'b0;
      #1;
      chk_reset_values("rst_debounce");
      #1;
      drive(3'b000, 3);
      rst = 1'b1;
      drive(3'b000, 2);
      chk("rst_restart_row", int'(kif.row_out), 1);

      // reset while pressed
      wait_row_entry(4'b0100);
      drive(3'b001, 10);
      chk("pre_rst_code", int'(kif.key_code), 7);
      chk("pre_rst_held", int'(kif.key_held), 1);
      rst = 1'b0;
      #1;
      chk_reset_values("rst_pressed");
      #1;
      drive(3'b000, 3);
      v0 = n_valid; e0 = n_err;
      rst = 1'b1;
      drive(3'b000, 20);
      chk("post_rst_pulses", (n_valid - v0) + (n_err - e0), 0);

      // random presses
      for (int it = 0; it < 40; it++) begin
         int r, nb;
         logic [2:0] c;
         r  = $urandom_range(0, 3);
         c  = 3'($urandom_range(1, 7));
         nb = $urandom_range(0, 2);
         wait_row_entry(4'(1 << r));
         for (int b = 0; b < nb; b++) begin
            drive(c, 1);
            drive(3'b000, $urandom_range(1, 2));
         end
         drive(c, $urandom_range(5, 15));
         if ($urandom_range(0, 1) == 1) begin
            drive(3'b000, 1);
            drive(3'($urandom_range(1, 7)), $urandom_range(1, 4));
         end
         drive(3'b000, $urandom_range(1, 12));
         chk("code_range", int'(kif.key_code > 4'd11), 0);
      end
      drive(3'b000, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
